// File: rtl/tx_frame_builder.sv
// Wraps an upstream byte stream into TX FIFO frames: SOF marker, payload, XOR-checksum EOF.
// Oversized frames are closed with an abort word and the rest of the frame is discarded.
module tx_frame_builder #(
  parameter int unsigned MAX_LEN = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  input  logic       s_last,
  output logic       s_ready,
  input  logic       tx_en,
  input  logic       flush,
  output logic       fifo_wr_en,
  output logic [9:0] fifo_wr_data,
  output logic       frame_done,
  output logic       frame_abort,
  output logic       busy
);

  localparam int unsigned CW = $clog2(MAX_LEN + 1);

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    EOF,
    OVF,
    DROP
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      csum_q, csum_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            ready;
  logic            wr_en;
  logic [9:0]      wr_data;
  logic            done;
  logic            abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      csum_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      csum_q  <= csum_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    csum_d  = csum_q;
    cnt_d   = cnt_q;
    ready   = 1'b0;
    wr_en   = 1'b0;
    wr_data = '0;
    done    = 1'b0;
    abort   = 1'b0;

    if (flush) begin
      // Aborting from DROP would double-report: the OVF word already pulsed abort.
      state_d = IDLE;
      csum_d  = '0;
      cnt_d   = '0;
      abort   = (state_q == DATA) || (state_q == EOF) || (state_q == OVF);
    end else begin
      unique case (state_q)
        IDLE: begin
          if (s_valid && tx_en) begin
            wr_en   = 1'b1;
            wr_data = {2'b01, 8'hA5};
            csum_d  = '0;
            cnt_d   = '0;
            state_d = DATA;
          end
        end
        DATA: begin
          ready = tx_en;
          if (s_valid && tx_en) begin
            wr_en   = 1'b1;
            wr_data = {2'b00, s_data};
            csum_d  = csum_q ^ s_data;
            cnt_d   = cnt_q + CW'(1);
            if (s_last) begin
              state_d = EOF;
            end else if (cnt_d == CW'(MAX_LEN)) begin
              state_d = OVF;
            end
          end
        end
        EOF: begin
          if (tx_en) begin
            wr_en   = 1'b1;
            wr_data = {2'b10, csum_q};
            done    = 1'b1;
            state_d = IDLE;
          end
        end
        OVF: begin
          if (tx_en) begin
            wr_en   = 1'b1;
            wr_data = {2'b11, 8'hFF};
            abort   = 1'b1;
            state_d = DROP;
          end
        end
        DROP: begin
          ready = 1'b1;
          if (s_valid && s_last) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs are forced low for the whole time reset is held, not just after the edge.
  assign s_ready      = rst_n && ready;
  assign fifo_wr_en   = rst_n && wr_en;
  assign fifo_wr_data = rst_n ? wr_data : '0;
  assign frame_done   = rst_n && done;
  assign frame_abort  = rst_n && abort;
  assign busy         = rst_n && (state_q != IDLE);

endmodule
